// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: single writer for the register file write port.
// Merges in-order ALU results with long-latency results buffered in a small FIFO.
module regfile_wb_arbiter #(
    parameter int IS_DEPTH     = 5,
    parameter int REGF_WIDTH   = 32,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wr_valid,
    input  logic [IS_DEPTH-1:0]   alu_rd,
    input  logic [REGF_WIDTH-1:0] alu_data,
    input  logic                  lsu_wr_valid,
    output logic                  lsu_wr_ready,
    input  logic [IS_DEPTH-1:0]   lsu_rd,
    input  logic [REGF_WIDTH-1:0] lsu_data,
    output logic                  regWrite,
    output logic [IS_DEPTH-1:0]   rd,
    output logic [REGF_WIDTH-1:0] data_wr,
    input  logic [IS_DEPTH-1:0]   query_rs1,
    input  logic [IS_DEPTH-1:0]   query_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  drain_stall
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [IS_DEPTH-1:0]   ent_rd_q   [QDEPTH];
    logic [REGF_WIDTH-1:0] ent_data_q [QDEPTH];
    logic [QDEPTH-1:0]     ent_live_q, ent_live_d;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;

    logic                  we_q, we_d;
    logic [IS_DEPTH-1:0]   rd_q, rd_d;
    logic [REGF_WIDTH-1:0] data_q, data_d;

    logic fifo_empty;
    logic alu_issue;
    logic lsu_enq;
    logic pop;
    logic head_issue;

    assign fifo_empty   = (count_q == '0);
    assign lsu_wr_ready = (count_q < CW'(QDEPTH));
    assign alu_issue    = alu_wr_valid && (alu_rd != '0);
    // A handshake to x0 still completes, it just never occupies an entry.
    assign lsu_enq      = lsu_wr_valid && lsu_wr_ready && (lsu_rd != '0);
    assign pop          = !alu_issue && !fifo_empty;
    assign head_issue   = pop && ent_live_q[head_q];

    assign drain_stall  = (count_q == CW'(QDEPTH)) || (starve_q == SW'(STARVE_LIMIT));

    assign regWrite = we_q;
    assign rd       = rd_q;
    assign data_wr  = data_q;

    // Supersede kills land before the enqueue so a same-cycle LSU entry stays live.
    always_comb begin
        ent_live_d = ent_live_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (alu_issue && (ent_rd_q[i] == alu_rd)) begin
                ent_live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            ent_live_d[head_q] = 1'b0;
        end
        if (lsu_enq) begin
            ent_live_d[tail_q] = 1'b1;
        end
    end

    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = lsu_enq ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({lsu_enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (alu_issue && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Idle slots keep rd/data_wr at their last value; only the enable drops.
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (alu_issue) begin
            we_d   = 1'b1;
            rd_d   = alu_rd;
            data_d = alu_data;
        end else if (head_issue) begin
            we_d   = 1'b1;
            rd_d   = ent_rd_q[head_q];
            data_d = ent_data_q[head_q];
        end
    end

    always_comb begin
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_live_q[i] && (ent_rd_q[i] == query_rs1)) begin
                busy_rs1 = 1'b1;
            end
            if (ent_live_q[i] && (ent_rd_q[i] == query_rs2)) begin
                busy_rs2 = 1'b1;
            end
        end
        if (query_rs1 == '0) begin
            busy_rs1 = 1'b0;
        end
        if (query_rs2 == '0) begin
            busy_rs2 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_live_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            ent_live_q <= ent_live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    // Payload needs no reset: an entry is only observed while its live bit is set.
    always_ff @(posedge clk) begin
        if (lsu_enq) begin
            ent_rd_q[tail_q]   <= lsu_rd;
            ent_data_q[tail_q] <= lsu_data;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that is the single writer for the register file's one write port. It merges in-order ALU/pipeline results with out-of-order long-latency results (loads, multi-cycle units), buffering the latter in a small FIFO. It drives registered `regWrite`/`rd`/`data_wr` toward the register file, which commits on the falling edge. It also reports pending destinations to decode for hazard detection.

## Interface
- `IS_DEPTH`, 5, register index width
- `REGF_WIDTH`, 32, data width
- `QDEPTH`, 4, long-latency FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, cycles the FIFO head may wait before stall is requested

- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `alu_wr_valid` in 1 — pipeline result present this cycle (no backpressure)
- `alu_rd` in IS_DEPTH — pipeline destination
- `alu_data` in REGF_WIDTH — pipeline result
- `lsu_wr_valid` in 1 — long-latency result offered
- `lsu_wr_ready` out 1 — FIFO can accept; transfer on valid&&ready
- `lsu_rd` in IS_DEPTH — long-latency destination
- `lsu_data` in REGF_WIDTH — long-latency result
- `regWrite` out 1 — register-file write enable (registered)
- `rd` out IS_DEPTH — register-file write index (registered)
- `data_wr` out REGF_WIDTH — register-file write data (registered)
- `query_rs1`, `query_rs2` in IS_DEPTH — decode source indices
- `busy_rs1`, `busy_rs2` out 1 — a live FIFO entry targets that index
- `drain_stall` out 1 — request to pipeline to insert a bubble (hold `alu_wr_valid` low)

## Operation
- Reset: `regWrite`=0, `rd`=0, `data_wr`=0, FIFO empty (all entries dead), starve counter 0, `drain_stall`=0; `lsu_wr_ready`=1 because count is 0.
- Writes with index 0 are discarded from either source. A discarded ALU write is not issued. An LSU handshake to x0 completes (ready honoured) but nothing is enqueued.
- Each cycle selects at most one write for the output register, in priority order:
  1. ALU write (valid, rd≠0).
  2. Otherwise, the FIFO head if it is live. The head is popped.
  3. Otherwise, nothing: `regWrite`=0 next cycle, and `rd`/`data_wr` hold their previous value.
- A dead FIFO head is popped without issuing a write, consuming that cycle's slot.
- Supersede rule: an issued ALU write to X kills every live FIFO entry with rd==X. This is evaluated before that cycle's enqueue.
- An LSU entry accepted in the same cycle as an ALU write to the same X is enqueued live and writes later; the LSU value is final.
- `lsu_wr_ready` = count < QDEPTH, from registered count only; a same-cycle pop gives no credit.
- Enqueue and pop may occur in the same cycle. Count changes by +1, −1 or 0 accordingly.
- Pointers wrap modulo QDEPTH. Full and empty are distinguished by count, not by pointer equality.
- `busy_rsN` = OR over live entries of (entry.rd == query_rsN), forced 0 when the query is 0. Combinational.
- Starve counter:
  - Increments each cycle FIFO is non-empty and ALU wins.
  - Clears on any pop or when FIFO is empty.
  - Saturates at STARVE_LIMIT.
- `drain_stall` = (count == QDEPTH) || (starve == STARVE_LIMIT). Registered-state based, combinational output.
- If the ALU is still valid while `drain_stall`=1, the ALU still wins. This is a pipeline contract violation and is not flagged.

## Timing
- Latency: a selected write appears on `regWrite`/`rd`/`data_wr` after the next rising edge. The register file commits it at the following falling edge, in the same cycle.
- ALU result accepted in cycle N is committed at the negedge of cycle N+1.
- LSU result, with empty FIFO and no ALU traffic: handshake in N, pop in N+1, commit at the negedge of N+2.
- `busy` covers only FIFO residency, not the output register. Once the output register holds the write, decode reads the value after that cycle's negedge commit.
- Asserting reset mid-operation immediately clears all outputs and drops queued entries. No partial write is issued after release.

## Test plan
- Reset release → `regWrite`=0, `rd`=0, `data_wr`=0, `lsu_wr_ready`=1, `drain_stall`=0, `busy_rs1`/`busy_rs2`=0.
- ALU x5=0x11 in cycle 1 → `regWrite`=1, `rd`=5, `data_wr`=0x11 in cycle 2. ALU x0=0xFF → no write issued.
- Four LSU writes x1..x4 (0xA1..0xA4) while ALU is busy every cycle → `lsu_wr_ready`=0 at count 4, `drain_stall`=1. Drop ALU for 4 cycles → x1..x4 written in order, then `lsu_wr_ready`=1.
- LSU x7=0xBEEF queued, then ALU x7=0x1234 → x7 is written only once with 0x1234, and `busy_rs1`(query 7) drops in the same cycle.
- Same-cycle ALU x9=0x1 and LSU x9=0x2 → x9=0x1 next cycle, then x9=0x2 on drain.
- Head blocked by back-to-back ALU writes for STARVE_LIMIT=8 cycles → `drain_stall`=1 on cycle 8, head pops on the first ALU-idle cycle, and the counter clears.
